uart_loopback_checker: RTL and testbench



---
 rtl/uart_checker_pkg.sv | 34 +++
 rtl/uart_checker_patgen.sv | 57 +++++
 rtl/uart_loopback_checker.sv | 160 ++++++++++++++++
 tb/tb_uart_loopback_checker.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_checker_pkg.sv
// Shared types and constants for the UART loopback checker.
// Optional feature macro: UART_CHECKER_LFSR_EN (LFSR pattern instead of incrementing byte).
package uart_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAITRX = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Feedback taps of the 8-bit Fibonacci LFSR: bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int unsigned SYSCLKFRQ    = 12000000;
    localparam int unsigned BITCLKFRQ    = 115200;
    localparam int unsigned BIT_CYCLES   = SYSCLKFRQ / BITCLKFRQ;
    localparam int unsigned FRAME_CYCLES = 10 * BIT_CYCLES;

    // About 11.5 frames of margin, rounded up to a whole thousand cycles (12000)
    localparam int unsigned DEF_TIMEOUT_CYCLES =
        ((FRAME_CYCLES * 23 / 2 + 999) / 1000) * 1000;

    // Next LFSR state: shift left, feedback is parity of the tapped bits
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01
    function automatic logic [7:0] lfsr_seed_fix(input logic [7:0] seed);
        return (seed == 8'h00) ? 8'h01 : seed;
    endfunction

endpackage

// File: rtl/uart_checker_patgen.sv
// Expected-byte pattern generator for the loopback checker.
// UART_CHECKER_LFSR_EN defined: 8-bit Fibonacci LFSR from SEED (00 -> 01).
// Otherwise: incrementing byte starting at 00, wrapping FF -> 00.
module uart_checker_patgen
    import uart_checker_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       adv,
    output logic [7:0] pat
);

`ifdef UART_CHECKER_LFSR_EN
    localparam logic [7:0] PAT_START = lfsr_seed_fix(SEED);
`else
    // Counter mode always starts at 00; the seed is masked out
    localparam logic [7:0] PAT_START = SEED & 8'h00;
`endif

    logic [7:0] pat_d;
    logic [7:0] pat_q;
    logic [7:0] pat_nxt;

    // Successor of the current pattern byte
    always_comb begin
`ifdef UART_CHECKER_LFSR_EN
        pat_nxt = lfsr_next(pat_q);
`else
        pat_nxt = pat_q + 8'd1;
`endif
    end

    // Restart on init, step on adv, otherwise hold
    always_comb begin
        pat_d = pat_q;
        if (init) begin
            pat_d = PAT_START;
        end else if (adv) begin
            pat_d = pat_nxt;
        end
    end

    // Pattern register
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= PAT_START;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat = pat_q;

endmodule

// File: rtl/uart_loopback_checker.sv
// Self-test initiator for a UART echo path: sends a byte pattern through
// uart_m, checks each echoed byte, reports pass/fail, error count and timeout.
// Optional feature macro: UART_CHECKER_LFSR_EN (selects LFSR pattern in the generator).
module uart_loopback_checker
    import uart_checker_pkg::*;
#(
    parameter int unsigned NBYTES         = 256,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [7:0]  LFSR_SEED      = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       load,
    output logic [7:0] d,
    input  logic       txbusy,
    input  logic       bytercvd,
    input  logic [7:0] q,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] errcnt,
    output logic       timeout
);

    localparam int unsigned BCW = $clog2(NBYTES + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    state_e         state_q, state_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic [7:0]     errcnt_q, errcnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           pass_q, pass_d;
    logic           timeout_q, timeout_d;
    logic           pat_init;
    logic           pat_adv;
    logic           err_inc;
    logic           finish;

    uart_checker_patgen #(
        .SEED (LFSR_SEED)
    ) u_patgen (
        .clk  (clk),
        .rst  (rst),
        .init (pat_init),
        .adv  (pat_adv),
        .pat  (d)
    );

    // Next-state, counters and status; load is a same-cycle strobe on txbusy=0
    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        errcnt_d  = errcnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        load      = 1'b0;
        pat_init  = 1'b0;
        pat_adv   = 1'b0;
        err_inc   = 1'b0;
        finish    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // Strobes outside a run are ignored (busy is 0 here)
                if (start) begin
                    state_d   = SEND;
                    bcnt_d    = '0;
                    tcnt_d    = '0;
                    errcnt_d  = 8'd0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    pat_init  = 1'b1;
                end
            end
            SEND: begin
                // Nothing is outstanding, so any strobe here is unexpected
                if (bytercvd) begin
                    err_inc = 1'b1;
                end
                if (!txbusy) begin
                    load    = 1'b1;
                    tcnt_d  = '0;
                    state_d = WAITRX;
                end
            end
            WAITRX: begin
                tcnt_d = tcnt_q + TCW'(1);
                // A strobe in the same cycle as the timeout takes priority
                if (bytercvd) begin
                    if (q != d) begin
                        err_inc = 1'b1;
                    end
                    pat_adv = 1'b1;
                    bcnt_d  = bcnt_q + BCW'(1);
                    if (bcnt_d == BCW'(NBYTES)) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end else if (tcnt_d == TCW'(TIMEOUT_CYCLES)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                    finish    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (err_inc && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end

        if (finish) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (errcnt_d == 8'd0) && !timeout_d;
        end
    end

    // State and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            tcnt_q    <= '0;
            errcnt_q  <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            tcnt_q    <= tcnt_d;
            errcnt_q  <= errcnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign errcnt  = errcnt_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_loopback_checker.sv
// Bench for uart_loopback_checker: behavioural uart_m/echo model with random
// delays, corruption and stray strobes; expected bytes from a reference pattern.
// Honours UART_CHECKER_LFSR_EN for the reference pattern.
module tb_uart_loopback_checker;

    localparam int unsigned NB         = 6;
    localparam int unsigned TO         = 120;
    localparam logic [7:0]  SEED       = 8'h00;
    localparam int unsigned RUN_BUDGET = NB * (TO + 40) + 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       load;
    logic [7:0] d;
    logic       txbusy;
    logic       bytercvd;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] errcnt;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    // Environment state
    int          cyc;
    logic        echo_on;
    int          echo_t;
    logic [7:0]  echo_b;
    int          tx_t;
    logic        force_busy;
    logic        stray;
    logic        mute;
    int          fixed_delay;
    logic [NB-1:0] corrupt;
    int          nsent;
    int          last_load_cyc;
    logic [7:0]  last_d;
    logic        load_seen;
    logic [7:0]  exp_bytes [NB];

    uart_loopback_checker #(
        .NBYTES         (NB),
        .TIMEOUT_CYCLES (TO),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load     (load),
        .d        (d),
        .txbusy   (txbusy),
        .bytercvd (bytercvd),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .errcnt   (errcnt),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference pattern, written from the arithmetic definition
    function automatic logic [7:0] ref_first();
`ifdef UART_CHECKER_LFSR_EN
        return (SEED == 8'h00) ? 8'h01 : SEED;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] ref_next(input logic [7:0] x);
`ifdef UART_CHECKER_LFSR_EN
        int v;
        int fb;
        v  = int'(x);
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v * 2) % 256) + fb);
`else
        return 8'((int'(x) + 1) % 256);
`endif
    endfunction

    // One clock: drive uart_m model inputs, then observe load and scoreboard it
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        txbusy = force_busy || (tx_t > 0);
        if (tx_t > 0) tx_t--;
        bytercvd = 1'b0;
        q = 8'($urandom);
        if (echo_on) begin
            if (echo_t <= 1) begin
                bytercvd = 1'b1;
                q        = echo_b;
                echo_on  = 1'b0;
                check("d_stable_until_echo", d, last_d);
            end else begin
                echo_t--;
            end
        end else if (stray) begin
            bytercvd = 1'b1;
        end
        stray = 1'b0;
        #1;
        load_seen = load;
        if (load) begin
            check("load_while_txbusy", txbusy, 0);
            check("load_count_in_range", (nsent < NB), 1);
            if (nsent < NB) begin
                check("tx_byte", d, exp_bytes[nsent]);
                last_d        = d;
                last_load_cyc = cyc;
                if (!mute) begin
                    echo_on = 1'b1;
                    if (fixed_delay != 0) echo_t = fixed_delay;
                    else if ($urandom_range(3) == 0) echo_t = TO;
                    else echo_t = int'($urandom_range(TO, 1));
                    echo_b = d ^ {7'd0, corrupt[nsent]};
                end
                nsent++;
            end
            tx_t = int'($urandom_range(15));
        end
    endtask

    task automatic begin_run(input logic [NB-1:0] corr);
        logic [7:0] p;
        corrupt = corr;
        nsent   = 0;
        p       = ref_first();
        for (int i = 0; i < NB; i++) begin
            exp_bytes[i] = p;
            p            = ref_next(p);
        end
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < RUN_BUDGET) begin
            step();
            n++;
        end
        check({tag, "_done_within_budget"}, done, 1);
    endtask

    task automatic end_run(input string tag, input int exp_err, input logic exp_to);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_timeout"}, timeout, exp_to);
        check({tag, "_errcnt"}, errcnt, (exp_err > 255) ? 255 : exp_err);
        check({tag, "_pass"}, pass, (exp_err == 0) && !exp_to);
        check({tag, "_bytes_sent"}, nsent, exp_to ? 1 : NB);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_load"}, load, 0);
        check({tag, "_d"}, d, ref_first());
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_errcnt"}, errcnt, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        int loads;
        int n;
        logic [NB-1:0] corr;

        rst = 1'b1; start = 1'b0; txbusy = 1'b0; bytercvd = 1'b0; q = 8'd0;
        cyc = 0; echo_on = 1'b0; echo_t = 0; echo_b = 8'd0; tx_t = 0;
        force_busy = 1'b0; stray = 1'b0; mute = 1'b0; fixed_delay = 0;
        corrupt = '0; nsent = 0; last_load_cyc = 0; last_d = 8'd0; load_seen = 1'b0;

        repeat (3) step();
        check_reset_values("reset");
        rst = 1'b0;
        step();

        // Clean run, every echo at the last allowed cycle
        fixed_delay = TO;
        begin_run('0);
        wait_done("clean_max_delay");
        end_run("clean_max_delay", 0, 1'b0);
        fixed_delay = 0;

        // Third byte echoed with bit0 flipped
        begin_run(NB'(4));
        wait_done("corrupt3");
        end_run("corrupt3", 1, 1'b0);

        // Random delays and corruption; a start mid-run must be ignored
        for (int r = 0; r < 3; r++) begin
            corr = NB'($urandom & $urandom);
            begin_run(corr);
            repeat ($urandom_range(30, 1)) step();
            if (busy) begin
                start = 1'b1;
                step();
                start = 1'b0;
            end
            wait_done("random");
            end_run("random", $countones(corr), 1'b0);
        end

        // txbusy held after start: no load, strays counted, then single-cycle load
        force_busy = 1'b1;
        begin_run('0);
        loads = 0;
        for (int i = 0; i < 50; i++) begin
            if (i % 16 == 5) stray = 1'b1;
            step();
            if (load_seen) loads++;
        end
        check("no_load_while_txbusy", loads, 0);
        check("stray_in_send_errcnt", errcnt, 3);
        force_busy = 1'b0;
        step();
        check("load_first_free_cycle", load_seen, 1);
        step();
        check("load_single_cycle", load_seen, 0);
        wait_done("held_busy");
        end_run("held_busy", 3, 1'b0);

        // Error counter saturation via stray strobes, plus one corrupted echo
        force_busy = 1'b1;
        begin_run(NB'(1));
        repeat (300) begin
            stray = 1'b1;
            step();
        end
        step();
        check("errcnt_saturated", errcnt, 255);
        force_busy = 1'b0;
        wait_done("saturate");
        end_run("saturate", 301, 1'b0);

        // Strobes after the run are ignored
        stray = 1'b1;
        step();
        step();
        check("idle_stray_errcnt", errcnt, 255);
        check("idle_stray_done", done, 1);

        // No echo: timeout after TO cycles, only one load ever issued
        mute = 1'b1;
        begin_run('0);
        n = 0;
        while (!timeout && n < TO + 50) begin
            step();
            n++;
        end
        check("timeout_seen", timeout, 1);
        check("timeout_latency", cyc - last_load_cyc, TO + 1);
        repeat (5) step();
        end_run("timeout", 0, 1'b1);
        mute = 1'b0;

        // Reset during WAITRX of byte 2, then a fresh run from the first byte
        fixed_delay = TO;
        begin_run('0);
        n = 0;
        while (!(nsent == 2 && echo_on) && n < RUN_BUDGET) begin
            step();
            n++;
        end
        check("reached_byte2_waitrx", nsent, 2);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        echo_on = 1'b0;
        tx_t = 0;
        check_reset_values("midrun_reset");
        step();
        fixed_delay = 0;
        begin_run('0);
        wait_done("after_reset");
        end_run("after_reset", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
